div_issue_ctrl: RTL and testbench

Request front-end that feeds the team's 16-bit sequential signed divider. It accepts operand requests over a valid/ready handshake and screens out divide-by-zero and overflow. It launches the divider with a one-cycle start pulse, drives the divider's clock-gate enable only while a division is in flight, and returns quotient, remainder, tag and error code over a response valid/ready handshake.

---
 rtl/div_pkg.sv | 25 ++
 rtl/div_screen.sv | 43 ++++
 rtl/div_issue_ctrl.sv | 151 +++++++++++++++
 tb/tb_div_issue_ctrl.sv | 363 ++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/div_pkg.sv
// Shared definitions for the divider issue controller: state encoding,
// response error codes and default widths.
package div_pkg;

    localparam int unsigned DEF_WIDTH = 16;
    localparam int unsigned DEF_TAG_W = 4;

    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_LAUNCH = 2'd1;
    localparam logic [1:0] ST_WAIT   = 2'd2;
    localparam logic [1:0] ST_RESP   = 2'd3;

    typedef enum logic [1:0] {
        StIdle   = ST_IDLE,
        StLaunch = ST_LAUNCH,
        StWait   = ST_WAIT,
        StResp   = ST_RESP
    } state_e;

    localparam logic [1:0] ERR_OK      = 2'd0;
    localparam logic [1:0] ERR_DIV0    = 2'd1;
    localparam logic [1:0] ERR_OVF     = 2'd2;
    localparam logic [1:0] ERR_TIMEOUT = 2'd3;

endpackage

// File: rtl/div_screen.sv
// Combinational screening of operands that must not reach the divider.
// Optional DIV_FASTPATH_EN also resolves divisors of +1/-1 locally.
module div_screen import div_pkg::*; #(
    parameter int unsigned WIDTH = DEF_WIDTH
) (
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             is_div0,
    output logic             is_ovf,
    output logic             is_fast,
    output logic [WIDTH-1:0] quot,
    output logic [WIDTH-1:0] rem
);

    localparam logic [WIDTH-1:0] MinNeg   = {1'b1, {(WIDTH-1){1'b0}}};
    localparam logic [WIDTH-1:0] MinusOne = '1;
`ifdef DIV_FASTPATH_EN
    localparam logic [WIDTH-1:0] PlusOne  = WIDTH'(1);
`endif

    always_comb begin
        is_div0 = (b == '0);
        is_ovf  = (a == MinNeg) && (b == MinusOne);
`ifdef DIV_FASTPATH_EN
        is_fast = !is_ovf && ((b == PlusOne) || (b == MinusOne));
`else
        is_fast = 1'b0;
`endif
        quot = '0;
        rem  = '0;
        if (is_div0) begin
            quot = '1;
            rem  = a;
        end else if (is_ovf) begin
            quot = a;
`ifdef DIV_FASTPATH_EN
        end else if (is_fast) begin
            quot = (b == PlusOne) ? a : (~a + PlusOne);
`endif
        end
    end

endmodule

// File: rtl/div_issue_ctrl.sv
// Request front-end for the sequential signed divider: screens special cases,
// launches the divider, gates its clock and returns responses. Macro: DIV_FASTPATH_EN.
module div_issue_ctrl import div_pkg::*; #(
    parameter int unsigned WIDTH   = DEF_WIDTH,
    parameter int unsigned TAG_W   = DEF_TAG_W,
    parameter int unsigned TIMEOUT = 24
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             req_valid,
    output logic             req_ready,
    input  logic [WIDTH-1:0] req_a,
    input  logic [WIDTH-1:0] req_b,
    input  logic [TAG_W-1:0] req_tag,
    output logic             resp_valid,
    input  logic             resp_ready,
    output logic [WIDTH-1:0] resp_quot,
    output logic [WIDTH-1:0] resp_rem,
    output logic [TAG_W-1:0] resp_tag,
    output logic [1:0]       resp_err,
    output logic             div_clk_en,
    output logic             div_start,
    output logic [WIDTH-1:0] div_a,
    output logic [WIDTH-1:0] div_b,
    input  logic             div_valid,
    input  logic [WIDTH-1:0] div_quot,
    input  logic [WIDTH-1:0] div_rem
);

    localparam int unsigned     CNT_W   = $clog2(TIMEOUT + 1);
    localparam logic [CNT_W-1:0] CntLast = CNT_W'(TIMEOUT - 1);

    state_e             state_q, state_d;
    logic [WIDTH-1:0]   a_q, a_d, b_q, b_d;
    logic [WIDTH-1:0]   quot_q, quot_d, rem_q, rem_d;
    logic [TAG_W-1:0]   tag_q, tag_d;
    logic [1:0]         err_q, err_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               drain_q, drain_d;
    logic               accept;

    logic               scr_div0, scr_ovf, scr_fast;
    logic [WIDTH-1:0]   scr_quot, scr_rem;

    div_screen #(
        .WIDTH (WIDTH)
    ) u_screen (
        .a       (req_a),
        .b       (req_b),
        .is_div0 (scr_div0),
        .is_ovf  (scr_ovf),
        .is_fast (scr_fast),
        .quot    (scr_quot),
        .rem     (scr_rem)
    );

    assign accept = req_valid && req_ready;

    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        b_d     = b_q;
        quot_d  = quot_q;
        rem_d   = rem_q;
        tag_d   = tag_q;
        err_d   = err_q;
        cnt_d   = cnt_q;
        drain_d = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (accept) begin
                    a_d   = req_a;
                    b_d   = req_b;
                    tag_d = req_tag;
                    if (scr_div0 || scr_ovf || scr_fast) begin
                        quot_d  = scr_quot;
                        rem_d   = scr_rem;
                        err_d   = scr_div0 ? ERR_DIV0 : (scr_ovf ? ERR_OVF : ERR_OK);
                        state_d = StResp;
                    end else begin
                        state_d = StLaunch;
                    end
                end
            end
            StLaunch: begin
                cnt_d   = '0;
                state_d = StWait;
            end
            StWait: begin
                cnt_d = cnt_q + 1'b1;
                // A result arriving on the last allowed cycle still beats the timeout.
                if (div_valid) begin
                    quot_d  = div_quot;
                    rem_d   = div_rem;
                    err_d   = ERR_OK;
                    drain_d = 1'b1;
                    state_d = StResp;
                end else if (cnt_q == CntLast) begin
                    quot_d  = '0;
                    rem_d   = '0;
                    err_d   = ERR_TIMEOUT;
                    drain_d = 1'b1;
                    state_d = StResp;
                end
            end
            StResp: begin
                if (resp_ready) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q <= StIdle;
            a_q     <= '0;
            b_q     <= '0;
            quot_q  <= '0;
            rem_q   <= '0;
            tag_q   <= '0;
            err_q   <= ERR_OK;
            cnt_q   <= '0;
            drain_q <= 1'b0;
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            quot_q  <= quot_d;
            rem_q   <= rem_d;
            tag_q   <= tag_d;
            err_q   <= err_d;
            cnt_q   <= cnt_d;
            drain_q <= drain_d;
        end
    end

    // Ready is masked while reset is held so nothing is accepted during reset.
    assign req_ready  = rst && (state_q == StIdle);
    assign resp_valid = (state_q == StResp);
    assign resp_quot  = quot_q;
    assign resp_rem   = rem_q;
    assign resp_tag   = tag_q;
    assign resp_err   = err_q;
    assign div_start  = (state_q == StLaunch);
    assign div_clk_en = (state_q == StLaunch) || (state_q == StWait) || drain_q;
    assign div_a      = a_q;
    assign div_b      = b_q;

endmodule

// File: tb/tb_div_issue_ctrl.sv
// Self-checking bench for div_issue_ctrl with a behavioural divider and a
// response scoreboard.
module tb_div_issue_ctrl;

    localparam int LAT = 4;

    typedef struct packed {
        logic [15:0] q;
        logic [15:0] r;
        logic [3:0]  t;
        logic [1:0]  e;
    } resp_t;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic [15:0] req_a = '0;
    logic [15:0] req_b = '0;
    logic [3:0]  req_tag = '0;
    logic        resp_valid;
    logic        resp_ready = 1'b0;
    logic [15:0] resp_quot, resp_rem;
    logic [3:0]  resp_tag;
    logic [1:0]  resp_err;
    logic        div_clk_en, div_start, div_valid;
    logic [15:0] div_a, div_b;
    logic [15:0] div_quot = '0;
    logic [15:0] div_rem = '0;

    logic        model_valid = 1'b0;
    logic        inject_valid = 1'b0;
    logic        withhold = 1'b0;
    logic        busy = 1'b0;
    int          left = 0;
    logic [15:0] m_a = '0;
    logic [15:0] m_b = '1;

    int starts = 0;
    int en_cyc = 0;
    int total = 0;
    int passed = 0;
    resp_t sb[$];

    always #5 clk = ~clk;

    div_issue_ctrl dut (
        .clk        (clk),
        .rst        (rst),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_a      (req_a),
        .req_b      (req_b),
        .req_tag    (req_tag),
        .resp_valid (resp_valid),
        .resp_ready (resp_ready),
        .resp_quot  (resp_quot),
        .resp_rem   (resp_rem),
        .resp_tag   (resp_tag),
        .resp_err   (resp_err),
        .div_clk_en (div_clk_en),
        .div_start  (div_start),
        .div_a      (div_a),
        .div_b      (div_b),
        .div_valid  (div_valid),
        .div_quot   (div_quot),
        .div_rem    (div_rem)
    );

    // Behavioural divider: result pulse LAT cycles after the start pulse.
    assign div_valid = model_valid | inject_valid;

    always @(posedge clk) begin
        model_valid <= 1'b0;
        if (div_start === 1'b1 && !withhold) begin
            busy <= 1'b1;
            left <= LAT;
            m_a  <= div_a;
            m_b  <= div_b;
        end else if (busy) begin
            left <= left - 1;
            if (left == 1) begin
                busy        <= 1'b0;
                model_valid <= 1'b1;
                div_quot    <= $signed(m_a) / $signed(m_b);
                div_rem     <= $signed(m_a) % $signed(m_b);
            end
        end
    end

    always @(posedge clk) begin
        if (div_start === 1'b1) starts <= starts + 1;
        if (div_clk_en === 1'b1) en_cyc <= en_cyc + 1;
    end

    function automatic resp_t model(input logic [15:0] a, input logic [15:0] b,
                                    input logic [3:0] t);
        resp_t x;
        logic signed [15:0] sa, sb_;
        sa  = a;
        sb_ = b;
        x.t = t;
        if (b == 16'h0000) begin
            x.q = 16'hFFFF; x.r = a; x.e = 2'd1;
        end else if (a == 16'h8000 && b == 16'hFFFF) begin
            x.q = 16'h8000; x.r = '0; x.e = 2'd2;
        end else begin
            x.q = sa / sb_; x.r = sa % sb_; x.e = 2'd0;
        end
        return x;
    endfunction

    // Drives one request; returns at the negedge just after the accepting edge.
    task automatic send(input logic [15:0] a, input logic [15:0] b, input logic [3:0] t);
        int n = 0;
        @(negedge clk);
        req_valid = 1'b1; req_a = a; req_b = b; req_tag = t;
        while (req_ready !== 1'b1 && n < 200) begin
            @(negedge clk);
            n++;
        end
        @(negedge clk);
        req_valid = 1'b0;
        req_a = 16'($urandom);
        req_b = 16'($urandom);
        req_tag = 4'($urandom);
    endtask

    task automatic collect(input int bound, output resp_t got);
        int n = 0;
        while (resp_valid !== 1'b1 && n < bound) begin
            @(negedge clk);
            n++;
        end
        if (resp_valid === 1'b1) begin
            got = {resp_quot, resp_rem, resp_tag, resp_err};
            resp_ready = 1'b1;
            @(negedge clk);
            resp_ready = 1'b0;
        end else begin
            got = 'x;
        end
    endtask

    task automatic do_normal(input logic [15:0] a, input logic [15:0] b, input logic [3:0] t,
                             input string name);
        int s0, e0;
        resp_t got, exp;
        s0 = starts;
        e0 = en_cyc;
        sb.push_back(model(a, b, t));
        send(a, b, t);
        total++;
        if (div_start !== 1'b1 || resp_valid !== 1'b0)
            $display("FAIL %s launch: div_start=%b resp_valid=%b, want 1/0", name, div_start,
                     resp_valid);
        else passed++;
        collect(100, got);
        exp = sb.pop_front();
        total++;
        if (got !== exp) $display("FAIL %s result: got %h want %h", name, got, exp);
        else passed++;
        total++;
        if (starts - s0 != 1 || en_cyc - e0 != LAT + 3 || div_clk_en !== 1'b0)
            $display("FAIL %s gating: starts=%0d en_cycles=%0d en_now=%b, want 1/%0d/0", name,
                     starts - s0, en_cyc - e0, div_clk_en, LAT + 3);
        else passed++;
    endtask

    task automatic do_screened(input logic [15:0] a, input logic [15:0] b, input logic [3:0] t,
                               input string name);
        int s0, e0;
        resp_t got, exp;
        s0 = starts;
        e0 = en_cyc;
        sb.push_back(model(a, b, t));
        send(a, b, t);
        total++;
        if (resp_valid !== 1'b1 || div_start !== 1'b0)
            $display("FAIL %s latency: resp_valid=%b div_start=%b, want 1/0", name, resp_valid,
                     div_start);
        else passed++;
        collect(100, got);
        exp = sb.pop_front();
        total++;
        if (got !== exp) $display("FAIL %s result: got %h want %h", name, got, exp);
        else passed++;
        total++;
        if (starts != s0 || en_cyc != e0)
            $display("FAIL %s no_launch: starts=%0d en_cycles=%0d, want 0/0", name, starts - s0,
                     en_cyc - e0);
        else passed++;
    endtask

    task automatic test_reset();
        repeat (2) @(negedge clk);
        total++;
        if (req_ready !== 1'b0) $display("FAIL reset_ready: got %b want 0", req_ready);
        else passed++;
        rst = 1'b1;
        @(negedge clk);
        total++;
        if ({req_ready, resp_valid, resp_quot, resp_rem, resp_tag, resp_err, div_start,
             div_clk_en, div_a, div_b} !== {1'b1, 1'b0, 16'h0, 16'h0, 4'h0, 2'd0, 1'b0, 1'b0,
             16'h0, 16'h0})
            $display("FAIL reset_state: rdy=%b rv=%b q=%h r=%h t=%h e=%0d st=%b en=%b a=%h b=%h",
                     req_ready, resp_valid, resp_quot, resp_rem, resp_tag, resp_err, div_start,
                     div_clk_en, div_a, div_b);
        else passed++;
    endtask

    task automatic test_normal();
        logic [15:0] a, b;
        do_normal(16'd100, 16'd7, 4'd3, "pos_pos");
        do_normal(-16'sd100, 16'd7, 4'd4, "neg_pos");
        do_normal(16'd100, -16'sd7, 4'd5, "pos_neg");
        for (int i = 0; i < 6; i++) begin
            a = 16'($urandom);
            b = 16'($urandom);
            while (b == 16'h0000 || b == 16'h0001 || b == 16'hFFFF) b = 16'($urandom);
            do_normal(a, b, 4'(i), "random");
        end
    endtask

    task automatic test_screens();
        do_screened(16'd5, 16'd0, 4'd1, "div0");
        do_screened(-16'sd7, 16'd0, 4'd2, "div0_neg");
        do_screened(16'h8000, 16'hFFFF, 4'd6, "ovf");
    endtask

    task automatic test_unit_divisors();
        resp_t got, exp;
        sb.push_back(model(16'd1234, 16'd1, 4'd7));
        send(16'd1234, 16'd1, 4'd7);
        collect(100, got);
        exp = sb.pop_front();
        total++;
        if (got !== exp) $display("FAIL unit_plus: got %h want %h", got, exp);
        else passed++;
        sb.push_back(model(16'h8001, 16'hFFFF, 4'd8));
        send(16'h8001, 16'hFFFF, 4'd8);
        collect(100, got);
        exp = sb.pop_front();
        total++;
        if (got !== exp) $display("FAIL unit_minus: got %h want %h", got, exp);
        else passed++;
    endtask

    task automatic test_timeout();
        int e0;
        resp_t got, exp;
        withhold = 1'b1;
        e0 = en_cyc;
        sb.push_back('{q: 16'h0, r: 16'h0, t: 4'd9, e: 2'd3});
        send(16'd500, 16'd3, 4'd9);
        collect(100, got);
        exp = sb.pop_front();
        total++;
        if (got !== exp) $display("FAIL timeout_result: got %h want %h", got, exp);
        else passed++;
        total++;
        if (en_cyc - e0 != 26) $display("FAIL timeout_gating: got %0d want 26", en_cyc - e0);
        else passed++;
        withhold = 1'b0;
        // A stray result pulse while idle must not produce a response.
        div_quot = 16'h1111;
        div_rem  = 16'h2222;
        inject_valid = 1'b1;
        @(negedge clk);
        inject_valid = 1'b0;
        @(negedge clk);
        total++;
        if (resp_valid !== 1'b0 || req_ready !== 1'b1)
            $display("FAIL late_valid: resp_valid=%b req_ready=%b want 0/1", resp_valid,
                     req_ready);
        else passed++;
        do_normal(16'd1234, 16'd56, 4'd10, "after_timeout");
    endtask

    task automatic test_back_to_back();
        int n = 0;
        resp_t snap, got, exp;
        sb.push_back(model(16'd1000, 16'd33, 4'd11));
        send(16'd1000, 16'd33, 4'd11);
        while (resp_valid !== 1'b1 && n < 100) begin
            @(negedge clk);
            n++;
        end
        snap = {resp_quot, resp_rem, resp_tag, resp_err};
        sb.push_back(model(-16'sd999, 16'd10, 4'd12));
        req_valid = 1'b1; req_a = -16'sd999; req_b = 16'd10; req_tag = 4'd12;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            total++;
            if ({resp_quot, resp_rem, resp_tag, resp_err, resp_valid, req_ready} !==
                {snap, 1'b1, 1'b0})
                $display("FAIL stall_hold: q=%h r=%h t=%h e=%0d rv=%b rdy=%b want %h rv=1 rdy=0",
                         resp_quot, resp_rem, resp_tag, resp_err, resp_valid, req_ready, snap);
            else passed++;
        end
        exp = sb.pop_front();
        total++;
        if (snap !== exp) $display("FAIL stall_result: got %h want %h", snap, exp);
        else passed++;
        resp_ready = 1'b1;
        @(negedge clk);
        resp_ready = 1'b0;
        total++;
        if (req_ready !== 1'b1 || resp_valid !== 1'b0)
            $display("FAIL stall_release: req_ready=%b resp_valid=%b want 1/0", req_ready,
                     resp_valid);
        else passed++;
        @(negedge clk);
        req_valid = 1'b0;
        collect(100, got);
        exp = sb.pop_front();
        total++;
        if (got !== exp) $display("FAIL second_req: got %h want %h", got, exp);
        else passed++;
    endtask

    task automatic test_reset_mid();
        withhold = 1'b1;
        send(16'd300, 16'd7, 4'd13);
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        total++;
        if (resp_valid !== 1'b0 || div_clk_en !== 1'b0 || req_ready !== 1'b0 ||
            div_start !== 1'b0)
            $display("FAIL reset_mid: rv=%b en=%b rdy=%b st=%b want 0/0/0/0", resp_valid,
                     div_clk_en, req_ready, div_start);
        else passed++;
        rst = 1'b1;
        withhold = 1'b0;
        @(negedge clk);
        total++;
        if (req_ready !== 1'b1 || resp_valid !== 1'b0 || div_a !== 16'h0)
            $display("FAIL reset_mid_idle: rdy=%b rv=%b div_a=%h want 1/0/0000", req_ready,
                     resp_valid, div_a);
        else passed++;
        do_normal(-16'sd32767, 16'd2, 4'd14, "after_reset");
    endtask

    initial begin
        test_reset();
        test_normal();
        test_screens();
        test_unit_divisors();
        test_timeout();
        test_back_to_back();
        test_reset_mid();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, %0d/%0d", passed, total);
        $fatal(1);
    end

endmodule
